// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Widest requester vector the round-robin helper handles.
  localparam int MAX_REQ = 8;

  // Width of a requester index.
  function automatic int tag_width_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set bit of req at or after ptr, wrapping modulo n.
  // Returns ptr when nothing is set; callers qualify with |req.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [2:0] w_pick;
    logic       w_found;
    int         w_idx;
    logic [2:0] w_idx3;
    w_pick  = ptr;
    w_found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      w_idx  = (int'(ptr) + k) % n;
      w_idx3 = w_idx[2:0];
      if ((k < n) && !w_found && req[w_idx3]) begin
        w_pick  = w_idx3;
        w_found = 1'b1;
      end
    end
    return w_pick;
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of requester tags for outstanding reads.
// A pop while empty is ignored; a push while full is accepted only when a
// pop frees the head slot in the same cycle.
module mem_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (r_wptr == r_rptr);
  assign full_o    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign dout_o    = r_mem[r_rptr[AW-1:0]];

  // Advance read/write pointers on accepted pops/pushes.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Tag storage; when full the head is read out before being overwritten.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one Avalon memory port between requesters.
// Read data returns to the issuing requester through an in-order tag FIFO;
// per-sample starvation is counted for firmware.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 22,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int OVR_CNT_WIDTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic                          sample_tick_i,
  input  logic                          ovr_clr_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [NUM_REQ-1:0]            rdata_val_o,
  output logic                          mem_read_o,
  output logic                          mem_write_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic                          mem_waitrequest_i,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  input  logic                          mem_rdata_val_i,
  output logic [OVR_CNT_WIDTH-1:0]      ovr_cnt_o,
  output logic                          err_o
);

  localparam int TAG_WIDTH = tag_width_f(NUM_REQ);

  state_t                   r_state;
  logic [TAG_WIDTH-1:0]     r_ptr;
  logic [TAG_WIDTH-1:0]     r_gnt;
  logic                     r_mem_read;
  logic                     r_mem_write;
  logic [ADDR_WIDTH-1:0]    r_mem_addr;
  logic [DATA_WIDTH-1:0]    r_mem_wdata;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [NUM_REQ-1:0]       r_rdata_val;
  logic [OVR_CNT_WIDTH-1:0] r_ovr_cnt;
  logic                     r_err;

  logic [NUM_REQ-1:0]       w_elig;
  logic [TAG_WIDTH-1:0]     w_pick;
  logic [TAG_WIDTH-1:0]     w_ptr_next;
  logic                     w_accept;
  logic [NUM_REQ-1:0]       w_ack;
  logic [NUM_REQ-1:0]       w_head_oh;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [TAG_WIDTH-1:0]     w_head;
  logic                     w_push;
  logic                     w_ovr_hit;

  // Writes are always eligible; reads only while a tag slot is free.
  assign w_elig     = req_i & (we_i | {NUM_REQ{!w_fifo_full}});
  assign w_pick     = TAG_WIDTH'(rr_pick(MAX_REQ'(w_elig), 3'(r_ptr), NUM_REQ));
  assign w_ptr_next = (r_gnt == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
  assign w_accept   = (r_state == ISSUE) && !mem_waitrequest_i;
  assign w_push     = w_accept && r_mem_read;
  assign w_ovr_hit  = sample_tick_i && (|(req_i & ~w_ack));

  // Acknowledge the granted requester in the cycle memory accepts the command.
  always_comb begin
    w_ack = '0;
    if (w_accept) begin
      w_ack[r_gnt] = 1'b1;
    end else begin
      w_ack = '0;
    end
  end

  // One-hot strobe for the requester that owns the oldest outstanding read.
  always_comb begin
    w_head_oh = '0;
    w_head_oh[w_head] = 1'b1;
  end

  mem_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TAG_WIDTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (w_push),
    .pop_i   (mem_rdata_val_i),
    .din_i   (r_gnt),
    .dout_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // Grant FSM: latch the winning command in IDLE, hold it through waitrequest.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_elig) begin
            r_gnt       <= w_pick;
            r_mem_read  <= !we_i[w_pick];
            r_mem_write <= we_i[w_pick];
            r_mem_addr  <= addr_i[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
            r_mem_wdata <= wdata_i[w_pick*DATA_WIDTH +: DATA_WIDTH];
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_waitrequest_i) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ptr       <= w_ptr_next;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Register returning read data and strobe the owner of the head tag.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_rdata     <= '0;
      r_rdata_val <= '0;
    end else if (mem_rdata_val_i && !w_fifo_empty) begin
      r_rdata     <= mem_rdata_i;
      r_rdata_val <= w_head_oh;
    end else begin
      r_rdata_val <= '0;
    end
  end

  // Saturating starvation counter; a clear beats a coincident overrun.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_ovr_cnt <= '0;
    end else if (ovr_clr_i) begin
      r_ovr_cnt <= '0;
    end else if (w_ovr_hit && (r_ovr_cnt != '1)) begin
      r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end
  end

  // Sticky flag for read data arriving with no read outstanding.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_err <= 1'b0;
    end else if (ovr_clr_i) begin
      r_err <= 1'b0;
    end else if (mem_rdata_val_i && w_fifo_empty) begin
      r_err <= 1'b1;
    end
  end

  assign ack_o       = w_ack;
  assign rdata_o     = r_rdata;
  assign rdata_val_o = r_rdata_val;
  assign mem_read_o  = r_mem_read;
  assign mem_write_o = r_mem_write;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign ovr_cnt_o   = r_ovr_cnt;
  assign err_o       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected
// acks, memory commands and read returns; a monitor pops and compares.
module tb_mem_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 22;
  localparam int DW = 16;

  logic             clk_i = 1'b0;
  logic             arst_i = 1'b1;
  logic             sample_tick_i = 1'b0;
  logic             ovr_clr_i = 1'b0;
  logic [NR-1:0]    req_i = '0;
  logic [NR-1:0]    we_i = '0;
  logic [NR*AW-1:0] addr_i = '0;
  logic [NR*DW-1:0] wdata_i = '0;
  logic             mem_waitrequest_i = 1'b0;
  logic [DW-1:0]    mem_rdata_i = '0;
  logic             mem_rdata_val_i = 1'b0;

  logic [NR-1:0]    ack_o, rdata_val_o;
  logic [DW-1:0]    rdata_o, mem_wdata_o;
  logic             mem_read_o, mem_write_o, err_o;
  logic [AW-1:0]    mem_addr_o;
  logic [15:0]      ovr_cnt_o;

  logic [NR-1:0]    w2_ack, w2_rdata_val;
  logic [DW-1:0]    w2_rdata, w2_wdata;
  logic             w2_read, w2_write, w2_err;
  logic [AW-1:0]    w2_addr;
  logic [1:0]       w2_ovr_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rem [NR];
  logic [NR-1:0]    pend = '0;

  logic [38:0] cmd_q [$];
  logic [3:0]  ack_q [$];
  logic [19:0] rd_q  [$];

  mem_port_arbiter dut (
    .clk_i(clk_i), .arst_i(arst_i), .sample_tick_i(sample_tick_i), .ovr_clr_i(ovr_clr_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ack_o(ack_o), .rdata_o(rdata_o), .rdata_val_o(rdata_val_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_waitrequest_i(mem_waitrequest_i),
    .mem_rdata_i(mem_rdata_i), .mem_rdata_val_i(mem_rdata_val_i),
    .ovr_cnt_o(ovr_cnt_o), .err_o(err_o)
  );

  mem_port_arbiter #(.OVR_CNT_WIDTH(2)) dut_sat (
    .clk_i(clk_i), .arst_i(arst_i), .sample_tick_i(sample_tick_i), .ovr_clr_i(ovr_clr_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ack_o(w2_ack), .rdata_o(w2_rdata), .rdata_val_o(w2_rdata_val),
    .mem_read_o(w2_read), .mem_write_o(w2_write), .mem_addr_o(w2_addr),
    .mem_wdata_o(w2_wdata), .mem_waitrequest_i(mem_waitrequest_i),
    .mem_rdata_i(mem_rdata_i), .mem_rdata_val_i(mem_rdata_val_i),
    .ovr_cnt_o(w2_ovr_cnt), .err_o(w2_err)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: request-hold protocol plus scoreboard pops on every DUT output event.
  always @(negedge clk_i) begin
    if (arst_i) begin
      pend = '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) chk($sformatf("req_held_until_ack[%0d]", i), {63'd0, req_i[i]}, 64'd1);
      end
      pend = req_i & ~ack_o;
      if (ack_o != 4'b0000) begin
        if (ack_q.size() == 0) chk("ack_unexpected", {60'd0, ack_o}, 64'd0);
        else chk("ack", {60'd0, ack_o}, {60'd0, ack_q.pop_front()});
      end
      if ((mem_read_o || mem_write_o) && !mem_waitrequest_i) begin
        if (cmd_q.size() == 0) begin
          chk("cmd_unexpected", {62'd0, mem_read_o, mem_write_o}, 64'd0);
        end else begin
          logic [38:0] e;
          e = cmd_q.pop_front();
          chk("cmd_rw", {62'd0, mem_read_o, mem_write_o}, {62'd0, !e[38], e[38]});
          if (e[38]) chk("cmd_write", {25'd0, mem_write_o, mem_addr_o, mem_wdata_o}, {25'd0, e});
          else       chk("cmd_read_addr", {42'd0, mem_addr_o}, {42'd0, e[37:16]});
        end
      end
      if (rdata_val_o != 4'b0000) begin
        if (rd_q.size() == 0) chk("rdata_unexpected", {60'd0, rdata_val_o}, 64'd0);
        else chk("rdata", {44'd0, rdata_val_o, rdata_o}, {44'd0, rd_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int n_acks);
    req_i[i] = 1'b1;
    we_i[i]  = we;
    addr_i[i*AW +: AW]  = a;
    wdata_i[i*DW +: DW] = d;
    rem[i] = n_acks;
  endtask

  task automatic expect_cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    ack_q.push_back(oh);
    cmd_q.push_back({we, a, d});
  endtask

  // Wait for n acks; each requester drops req after its remaining count hits zero.
  task automatic wait_acks(input int n, input int budget, input bit spacing);
    int seen = 0;
    int last = -1;
    logic [NR-1:0] drop;
    while (seen < n && budget > 0) begin
      @(negedge clk_i);
      budget--;
      if (ack_o != 4'b0000) begin
        drop = '0;
        for (int i = 0; i < NR; i++) begin
          if (ack_o[i]) begin
            seen++;
            if (spacing && last >= 0) chk("ack_spacing", 64'(cyc - last), 64'd2);
            last = cyc;
            if (rem[i] > 0) rem[i]--;
            if (rem[i] == 0) drop[i] = 1'b1;
          end
        end
        step();
        req_i = req_i & ~drop;
      end
    end
    if (seen < n) chk("ack_timeout", 64'(seen), 64'(n));
  endtask

  task automatic send_resp(input logic [DW-1:0] d, input logic [3:0] exp_val);
    if (exp_val != 4'b0000) rd_q.push_back({exp_val, d});
    mem_rdata_val_i = 1'b1;
    mem_rdata_i     = d;
    step();
    mem_rdata_val_i = 1'b0;
  endtask

  task automatic tick_pulse();
    sample_tick_i = 1'b1;
    step();
    sample_tick_i = 1'b0;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {53'd0, ack_o, rdata_val_o, mem_read_o, mem_write_o, err_o}, 64'd0);
    chk({tag, "_bus"},  {26'd0, mem_addr_o, mem_wdata_o}, 64'd0);
    chk({tag, "_data"}, {32'd0, rdata_o, ovr_cnt_o}, 64'd0);
  endtask

  task automatic reset_dut();
    arst_i = 1'b1;
    req_i = '0; we_i = '0; mem_waitrequest_i = 1'b0; mem_rdata_val_i = 1'b0;
    sample_tick_i = 1'b0; ovr_clr_i = 1'b0;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    step();
    chk_all_zero("reset");
    arst_i = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rem[i] = 0;
    step();
    reset_dut();

    // Single write from requester 2.
    set_req(2, 1'b1, 22'h001234, 16'hBEEF, 1);
    expect_cmd(2, 1'b1, 22'h001234, 16'hBEEF);
    step();
    chk("wr_latency", {41'd0, mem_write_o, mem_addr_o}, {41'd0, 1'b1, 22'h001234});
    wait_acks(1, 10, 1'b0);
    chk("wr_back_idle", {62'd0, mem_write_o, mem_read_o}, 64'd0);

    // Round robin with all four requesters writing continuously.
    reset_dut();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 22'(32'h100 + i), 16'(32'h1000 + i), 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) expect_cmd(i, 1'b1, 22'(32'h100 + i), 16'(32'h1000 + i));
    wait_acks(8, 40, 1'b1);

    // Waitrequest stall on a read from requester 1, then its data return.
    mem_waitrequest_i = 1'b1;
    set_req(1, 1'b0, 22'h0ABCD, 16'h0000, 1);
    expect_cmd(1, 1'b0, 22'h0ABCD, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_hold", {41'd0, mem_read_o, mem_addr_o}, {41'd0, 1'b1, 22'h0ABCD});
    end
    step();
    mem_waitrequest_i = 1'b0;
    chk("stall_hold_last", {41'd0, mem_read_o, mem_addr_o}, {41'd0, 1'b1, 22'h0ABCD});
    wait_acks(1, 5, 1'b0);
    step();
    send_resp(16'h00A5, 4'b0010);
    step();

    // Four reads fill the tag FIFO; a fifth read waits while a write proceeds.
    set_req(3, 1'b0, 22'h000030, 16'h0, 1); expect_cmd(3, 1'b0, 22'h000030, 16'h0); wait_acks(1, 10, 1'b0);
    set_req(0, 1'b0, 22'h00000A, 16'h0, 1); expect_cmd(0, 1'b0, 22'h00000A, 16'h0); wait_acks(1, 10, 1'b0);
    set_req(2, 1'b0, 22'h000020, 16'h0, 1); expect_cmd(2, 1'b0, 22'h000020, 16'h0); wait_acks(1, 10, 1'b0);
    set_req(1, 1'b0, 22'h000010, 16'h0, 1); expect_cmd(1, 1'b0, 22'h000010, 16'h0); wait_acks(1, 10, 1'b0);
    set_req(3, 1'b0, 22'h000031, 16'h0, 1);
    set_req(0, 1'b1, 22'h3FFFFF, 16'hFFFF, 1);
    expect_cmd(0, 1'b1, 22'h3FFFFF, 16'hFFFF);
    wait_acks(1, 10, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("full_blocks_read", {63'd0, mem_read_o}, 64'd0);
    end
    step();
    expect_cmd(3, 1'b0, 22'h000031, 16'h0);
    send_resp(16'h0011, 4'b1000);
    wait_acks(1, 10, 1'b0);
    send_resp(16'h0022, 4'b0001);
    send_resp(16'h0033, 4'b0100);
    send_resp(16'h0044, 4'b0010);
    send_resp(16'h0055, 4'b1000);
    step();

    // Overrun counting, clear, saturation in the 2-bit instance, clear priority.
    chk("ovr_start", {48'd0, ovr_cnt_o}, 64'd0);
    mem_waitrequest_i = 1'b1;
    set_req(2, 1'b0, 22'h000022, 16'h0, 1);
    expect_cmd(2, 1'b0, 22'h000022, 16'h0);
    for (int k = 0; k < 3; k++) tick_pulse();
    chk("ovr_three", {48'd0, ovr_cnt_o}, 64'd3);
    chk("ovr_three_w2", {62'd0, w2_ovr_cnt}, 64'd3);
    ovr_clr_i = 1'b1; step(); ovr_clr_i = 1'b0;
    chk("ovr_clear", {48'd0, ovr_cnt_o}, 64'd0);
    for (int k = 0; k < 5; k++) tick_pulse();
    chk("ovr_five", {48'd0, ovr_cnt_o}, 64'd5);
    chk("ovr_saturate_w2", {62'd0, w2_ovr_cnt}, 64'd3);
    sample_tick_i = 1'b1; ovr_clr_i = 1'b1; step();
    sample_tick_i = 1'b0; ovr_clr_i = 1'b0;
    chk("ovr_clear_wins", {48'd0, ovr_cnt_o}, 64'd0);
    sample_tick_i = 1'b1; mem_waitrequest_i = 1'b0;
    wait_acks(1, 5, 1'b0);
    sample_tick_i = 1'b0;
    chk("ovr_acked_no_count", {48'd0, ovr_cnt_o}, 64'd0);
    send_resp(16'h0777, 4'b0100);
    step();

    // Spurious read data with nothing outstanding.
    chk("err_before", {63'd0, err_o}, 64'd0);
    send_resp(16'h0BAD, 4'b0000);
    chk("err_spurious", {63'd0, err_o}, 64'd1);
    chk("spurious_no_strobe", {60'd0, rdata_val_o}, 64'd0);
    ovr_clr_i = 1'b1; step(); ovr_clr_i = 1'b0;
    chk("err_cleared", {63'd0, err_o}, 64'd0);

    // Asynchronous reset while a read is stalled in ISSUE.
    mem_waitrequest_i = 1'b1;
    set_req(1, 1'b0, 22'h000055, 16'h0, 1);
    step();
    step();
    chk("pre_reset_issue", {63'd0, mem_read_o}, 64'd1);
    #2;
    arst_i = 1'b1;
    #1;
    chk_all_zero("async_reset");
    req_i = '0; mem_waitrequest_i = 1'b0; rem[1] = 0;
    step();
    arst_i = 1'b0;
    step();
    send_resp(16'h0123, 4'b0000);
    chk("err_late_rdv", {63'd0, err_o}, 64'd1);
    step();

    chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
    chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    chk("rd_q_drained",  64'(rd_q.size()),  64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
